// File: rtl/nmea_sentence_parser.sv
// NMEA-0183 sentence parser: filters one sentence ID, splits fields on ',', verifies '*hh',
// and commits only complete, verified sentences into an index-readable committed field bank.
module nmea_sentence_parser #(
  parameter logic [39:0] SENTENCE_ID    = "GPGGA",
  parameter bit          MATCH_TALKER   = 1'b1,
  parameter int          MAX_FIELDS     = 16,
  parameter int          FIELD_CHARS    = 12,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  localparam int         FIDX_W         = $clog2(MAX_FIELDS),
  localparam int         LEN_W          = $clog2(FIELD_CHARS + 1)
) (
  input  logic                     sclk,
  input  logic                     rstn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic [FIDX_W-1:0]        field_sel,
  output logic [8*FIELD_CHARS-1:0] field_data,
  output logic [LEN_W-1:0]         field_len,
  output logic [FIDX_W:0]          field_count,
  output logic [15:0]              talker_id,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic [2:0]               err_code,
  output logic                     busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ID, FIELD, CK1, CK2, CR, LF} state_t;
  typedef logic [8*FIELD_CHARS-1:0] fdata_t;
  typedef logic [LEN_W-1:0]         flen_t;

  state_t            state_q, state_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        ck_q, ck_d;
  logic [2:0]        id_pos_q, id_pos_d;
  logic [FIDX_W-1:0] fidx_q, fidx_d;
  logic [15:0]       talker_w_q, talker_w_d;
  logic [15:0]       talker_q, talker_d;
  logic [TO_W-1:0]   to_q, to_d;
  fdata_t            work_data_q [MAX_FIELDS];
  fdata_t            work_data_d [MAX_FIELDS];
  flen_t             work_len_q  [MAX_FIELDS];
  flen_t             work_len_d  [MAX_FIELDS];
  fdata_t            com_data_q  [MAX_FIELDS];
  fdata_t            com_data_d  [MAX_FIELDS];
  flen_t             com_len_q   [MAX_FIELDS];
  flen_t             com_len_d   [MAX_FIELDS];
  logic [FIDX_W:0]   com_count_q, com_count_d;
  fdata_t            field_data_q, field_data_d;
  flen_t             field_len_q, field_len_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [2:0]        err_code_q, err_code_d;

  logic [2:0]        err;
  logic [4:0]        hex;
  logic [7:0]        id_char;
  int                pos;

  // Returns {valid, nibble} for an ASCII hex digit in either case.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    return 5'd0;
  endfunction

  always_comb begin
    state_d       = state_q;
    xor_d         = xor_q;
    ck_d          = ck_q;
    id_pos_d      = id_pos_q;
    fidx_d        = fidx_q;
    talker_w_d    = talker_w_q;
    talker_d      = talker_q;
    to_d          = to_q;
    work_data_d   = work_data_q;
    work_len_d    = work_len_q;
    com_data_d    = com_data_q;
    com_len_d     = com_len_q;
    com_count_d   = com_count_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    field_data_d  = '0;
    field_len_d   = '0;
    err           = 3'd0;
    id_char       = 8'h00;
    hex           = hex_nib(rx_data);
    pos           = int'(work_len_q[fidx_q]);

    if (rx_valid) begin
      to_d = '0;
      // A '$' always opens a fresh frame, silently abandoning any frame in progress.
      if (rx_data == 8'h24) begin
        state_d     = ID;
        xor_d       = 8'h00;
        ck_d        = 8'h00;
        id_pos_d    = 3'd0;
        fidx_d      = '0;
        talker_w_d  = 16'h0000;
        work_data_d = '{default: '0};
        work_len_d  = '{default: '0};
      end else begin
        unique case (state_q)
          IDLE: ;
          ID: begin
            xor_d = xor_q ^ rx_data;
            if (id_pos_q == 3'd5) begin
              if (rx_data == 8'h2C) state_d = FIELD;
              else                  err     = 3'd1;
            end else begin
              id_char = SENTENCE_ID[8*(4-int'(id_pos_q)) +: 8];
              if (id_pos_q == 3'd0) talker_w_d[15:8] = rx_data;
              if (id_pos_q == 3'd1) talker_w_d[7:0]  = rx_data;
              if ((!MATCH_TALKER && id_pos_q < 3'd2) || rx_data == id_char)
                id_pos_d = id_pos_q + 3'd1;
              else
                err = 3'd1;
            end
          end
          FIELD: begin
            if (rx_data == 8'h2C) begin
              xor_d = xor_q ^ rx_data;
              if (fidx_q == FIDX_W'(MAX_FIELDS - 1)) err    = 3'd3;
              else                                   fidx_d = fidx_q + FIDX_W'(1);
            end else if (rx_data == 8'h2A) begin
              state_d = CK1;
            end else if (pos == FIELD_CHARS) begin
              err = 3'd2;
            end else begin
              xor_d = xor_q ^ rx_data;
              work_data_d[fidx_q][8*(FIELD_CHARS-1-pos) +: 8] = rx_data;
              work_len_d[fidx_q] = work_len_q[fidx_q] + flen_t'(1);
            end
          end
          CK1: begin
            if (hex[4]) begin
              ck_d[7:4] = hex[3:0];
              state_d   = CK2;
            end else err = 3'd4;
          end
          CK2: begin
            if (hex[4]) begin
              ck_d[3:0] = hex[3:0];
              state_d   = CR;
            end else err = 3'd4;
          end
          CR: begin
            if (rx_data == 8'h0D) state_d = LF;
            else                  err     = 3'd6;
          end
          LF: begin
            if (rx_data != 8'h0A) err = 3'd6;
            else if (ck_q != xor_q) err = 3'd5;
            else begin
              com_data_d    = work_data_q;
              com_len_d     = work_len_q;
              com_count_d   = (FIDX_W+1)'(fidx_q) + (FIDX_W+1)'(1);
              talker_d      = talker_w_q;
              frame_valid_d = 1'b1;
              state_d       = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) err  = 3'd7;
      else                                   to_d = to_q + TO_W'(1);
    end

    if (err != 3'd0) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_code_d  = err;
    end

    // Reads come from the next-state bank so a same-cycle commit is already visible.
    if ({1'b0, field_sel} < com_count_d) begin
      field_data_d = com_data_d[field_sel];
      field_len_d  = com_len_d[field_sel];
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      xor_q         <= 8'h00;
      ck_q          <= 8'h00;
      id_pos_q      <= 3'd0;
      fidx_q        <= '0;
      talker_w_q    <= 16'h0000;
      talker_q      <= 16'h0000;
      to_q          <= '0;
      work_data_q   <= '{default: '0};
      work_len_q    <= '{default: '0};
      com_data_q    <= '{default: '0};
      com_len_q     <= '{default: '0};
      com_count_q   <= '0;
      field_data_q  <= '0;
      field_len_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 3'd0;
    end else begin
      state_q       <= state_d;
      xor_q         <= xor_d;
      ck_q          <= ck_d;
      id_pos_q      <= id_pos_d;
      fidx_q        <= fidx_d;
      talker_w_q    <= talker_w_d;
      talker_q      <= talker_d;
      to_q          <= to_d;
      work_data_q   <= work_data_d;
      work_len_q    <= work_len_d;
      com_data_q    <= com_data_d;
      com_len_q     <= com_len_d;
      com_count_q   <= com_count_d;
      field_data_q  <= field_data_d;
      field_len_q   <= field_len_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign field_data  = field_data_q;
  assign field_len   = field_len_q;
  assign field_count = com_count_q;
  assign talker_id   = talker_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_nmea_sentence_parser.sv
// Directed bench for nmea_sentence_parser: a table of whole sentences with hand-computed outcomes,
// plus sequences for field reads, timeout, mid-frame restart and mid-frame reset.
module tb_nmea_sentence_parser;

  localparam int TO = 500;

  logic        sclk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  field_sel = 4'd0;

  logic [95:0] field_data, s_field_data;
  logic [3:0]  field_len, s_field_len;
  logic [4:0]  field_count, s_field_count;
  logic [15:0] talker_id, s_talker_id;
  logic        frame_valid, s_frame_valid;
  logic        frame_err, s_frame_err;
  logic [2:0]  err_code, s_err_code;
  logic        busy, s_busy;

  // Wildcard-talker instance is the main subject; the strict instance shares the same stream.
  nmea_sentence_parser #(.SENTENCE_ID("GPGGA"), .MATCH_TALKER(1'b0), .MAX_FIELDS(16),
                         .FIELD_CHARS(12), .TIMEOUT_CYCLES(TO)) dut (
    .sclk(sclk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .field_sel(field_sel),
    .field_data(field_data), .field_len(field_len), .field_count(field_count),
    .talker_id(talker_id), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code), .busy(busy));

  nmea_sentence_parser #(.SENTENCE_ID("GPGGA"), .MATCH_TALKER(1'b1), .MAX_FIELDS(16),
                         .FIELD_CHARS(12), .TIMEOUT_CYCLES(TO)) dut_strict (
    .sclk(sclk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .field_sel(field_sel),
    .field_data(s_field_data), .field_len(s_field_len), .field_count(s_field_count),
    .talker_id(s_talker_id), .frame_valid(s_frame_valid), .frame_err(s_frame_err),
    .err_code(s_err_code), .busy(s_busy));

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0, fe_cnt = 0, sfv_cnt = 0, sfe_cnt = 0;
  int fv0, fe0, sfv0, sfe0, waited;

  always @(negedge sclk) begin
    if (frame_valid)   fv_cnt  <= fv_cnt + 1;
    if (frame_err)     fe_cnt  <= fe_cnt + 1;
    if (s_frame_valid) sfv_cnt <= sfv_cnt + 1;
    if (s_frame_err)   sfe_cnt <= sfe_cnt + 1;
  end

  typedef struct {
    string       sentence;
    bit          exp_valid;
    logic [2:0]  exp_err;
    int          exp_count;
    logic [15:0] exp_talker;
    bit          gn;
  } vec_t;

  vec_t vecs [13];

  string s0, s0_bad, s_gn;
  logic [63:0] t_lat;
  logic [47:0] t_time;
  logic [95:0] exp_lat, exp_time, exp_long;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge sclk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge sclk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic readCheck(input string name, input int sel, input logic [95:0] exp_d,
                           input int exp_l);
    field_sel = 4'(sel);
    @(posedge sclk);
    #1;
    checkOutput({name, "_data"}, field_data, exp_d);
    checkOutput({name, "_len"}, field_len, exp_l);
  endtask

  initial begin
    s0     = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\015\012";
    s0_bad = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48\015\012";
    s_gn   = "$GNGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*59\015\012";
    t_lat    = "4807.038";
    t_time   = "123519";
    exp_lat  = {t_lat, 32'h0};
    exp_time = {t_time, 48'h0};
    exp_long = "123456789012";

    vecs[0]  = '{s0, 1'b1, 3'd0, 14, "GP", 1'b0};
    vecs[1]  = '{s0_bad, 1'b0, 3'd5, 14, "GP", 1'b0};
    vecs[2]  = '{"$GPRMC,123519,A*00\015\012", 1'b0, 3'd1, 14, "GP", 1'b0};
    vecs[3]  = '{s_gn, 1'b1, 3'd0, 14, "GN", 1'b1};
    vecs[4]  = '{"$GPGGA,1234567890123,*00\015\012", 1'b0, 3'd2, 14, "GN", 1'b0};
    vecs[5]  = '{"$GPGGA,123456789012*78\015\012", 1'b1, 3'd0, 1, "GP", 1'b0};
    vecs[6]  = '{"$GPGGA,1*4G\015\012", 1'b0, 3'd4, 1, "GP", 1'b0};
    vecs[7]  = '{"$GPGGA,1*4B\012", 1'b0, 3'd6, 1, "GP", 1'b0};
    vecs[8]  = '{"$GPGGA,1*4b\015\012", 1'b1, 3'd0, 1, "GP", 1'b0};
    vecs[9]  = '{"$GPGGA,1*4B\015\015", 1'b0, 3'd6, 1, "GP", 1'b0};
    vecs[10] = '{"$GPGGAX,1*00\015\012", 1'b0, 3'd1, 1, "GP", 1'b0};
    vecs[11] = '{{"$GPGGA", ",,,,", ",,,,", ",,,,", ",,,,", "*56\015\012"},
                 1'b1, 3'd0, 16, "GP", 1'b0};
    vecs[12] = '{{"$GPGGA", ",,,,", ",,,,", ",,,,", ",,,,", ",", "*00\015\012"},
                 1'b0, 3'd3, 16, "GP", 1'b0};

    #3;
    checkOutput("reset_count", field_count, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err_code", err_code, 0);
    checkOutput("reset_talker", talker_id, 0);
    #20;
    @(negedge sclk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      fv0 = fv_cnt; fe0 = fe_cnt; sfv0 = sfv_cnt; sfe0 = sfe_cnt;
      applyStimulus(vecs[i].sentence);
      repeat (3) @(posedge sclk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), fv_cnt - fv0, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_err", i), fe_cnt - fe0, (vecs[i].exp_err != 3'd0));
      if (vecs[i].exp_err != 3'd0)
        checkOutput($sformatf("vec%0d_err_code", i), err_code, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_count", i), field_count, vecs[i].exp_count);
      checkOutput($sformatf("vec%0d_talker", i), talker_id, vecs[i].exp_talker);
      checkOutput($sformatf("vec%0d_busy", i), busy, 0);
      checkOutput($sformatf("vec%0d_strict_valid", i), sfv_cnt - sfv0,
                  vecs[i].exp_valid && !vecs[i].gn);
      checkOutput($sformatf("vec%0d_strict_err", i), sfe_cnt - sfe0,
                  (vecs[i].exp_err != 3'd0) || vecs[i].gn);
      if (vecs[i].gn) checkOutput($sformatf("vec%0d_strict_code", i), s_err_code, 1);
    end

    // Field reads on a committed sentence, then a corrupt sentence must leave them intact.
    applyStimulus(s0);
    readCheck("rd_sel1", 1, exp_lat, 8);
    readCheck("rd_sel0", 0, exp_time, 6);
    readCheck("rd_sel13", 13, 96'h0, 0);
    readCheck("rd_sel14", 14, 96'h0, 0);
    applyStimulus(s0_bad);
    readCheck("rd_after_err", 1, exp_lat, 8);
    applyStimulus("$GPGGA,123456789012*78\015\012");
    readCheck("rd_full_field", 0, exp_long, 12);

    // Timeout: stall after a partial frame.
    fe0 = fe_cnt;
    applyStimulus("$GPGGA,12");
    checkOutput("to_busy_open", busy, 1);
    repeat (400) @(posedge sclk);
    #1;
    checkOutput("to_not_early", fe_cnt - fe0, 0);
    waited = 0;
    while (fe_cnt == fe0 && waited < 300) begin
      @(posedge sclk);
      waited++;
    end
    repeat (2) @(posedge sclk);
    #1;
    checkOutput("to_fired", fe_cnt - fe0, 1);
    checkOutput("to_err_code", err_code, 7);
    checkOutput("to_busy_low", busy, 0);

    // '$' mid-frame restarts without an error.
    fv0 = fv_cnt; fe0 = fe_cnt;
    applyStimulus("$GPGGA,12");
    applyStimulus(s0);
    repeat (3) @(posedge sclk);
    #1;
    checkOutput("restart_no_err", fe_cnt - fe0, 0);
    checkOutput("restart_one_valid", fv_cnt - fv0, 1);

    // Reset mid-frame clears everything asynchronously.
    field_sel = 4'd1;
    applyStimulus("$GPGGA,12");
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", field_count, 0);
    checkOutput("rst_data", field_data, 0);
    checkOutput("rst_len", field_len, 0);
    checkOutput("rst_talker", talker_id, 0);
    checkOutput("rst_err_code", err_code, 0);
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    rstn = 1'b1;

    // Commit and read in the same cycle: read must see the new bank.
    fv0 = fv_cnt;
    applyStimulus(s0);
    checkOutput("commit_pulse", frame_valid, 1);
    checkOutput("commit_read_data", field_data, exp_lat);
    checkOutput("commit_read_len", field_len, 8);
    checkOutput("commit_count", field_count, 14);
    @(posedge sclk);
    #1;
    checkOutput("commit_pulse_end", frame_valid, 0);
    checkOutput("post_rst_valid", fv_cnt - fv0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
